reg_wb_queue: RTL and testbench
===============================

// Module: reg_wb_queue
// PURPOSE
//   Write-side companion of reg_file: buffers writeback requests (ALU/load results) in a small FIFO
//   and drives reg_file's single write port (write/WR/WD), one write per cycle, oldest first.
//   Sits between the MEM/WB stage and reg_file. Optionally forwards pending (not yet written) data
//   to the decode-stage read addresses so readers never see stale RD1/RD2.
// PARAMETERS
//   DEPTH   4    queue entries, power of two, 2..16
//   DATA_W  32   write-data width (matches reg_file WD)
//   ADDR_W  5    register-address width (matches reg_file WR/PR1/PR2)
// PORTS
//   clk        in   1       clock, all state updates on rising edge
//   reset      in   1       asynchronous, active-low; clears all state immediately
//   enq_valid  in   1       writeback request present
//   enq_ready  out  1       queue can accept; enq happens on posedge when enq_valid & enq_ready
//   enq_wr     in   ADDR_W  destination register
//   enq_wd     in   DATA_W  destination data
//   wb_hold    in   1       reg_file write port unavailable this cycle; head not popped
//   write      out  1       to reg_file write
//   WR         out  ADDR_W  to reg_file WR
//   WD         out  DATA_W  to reg_file WD
//   PR1, PR2   in   ADDR_W  decode-stage read addresses (same values driven to reg_file)
//   fwd1_hit   out  1       pending entry exists for PR1
//   fwd1_data  out  DATA_W  youngest pending data for PR1
//   fwd2_hit   out  1       pending entry exists for PR2
//   fwd2_data  out  DATA_W  youngest pending data for PR2
//   count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//   - Reset (reset==0, async): head/tail/count=0, all valid bits 0; write=0, WR=0, WD=0,
//     enq_ready=1, fwd*_hit=0, fwd*_data=0. Entry data RAM need not be cleared.
//   - Circular buffer, head/tail pointers wrap modulo DEPTH; count in 0..DEPTH.
//   - enq_ready = (count != DEPTH). No pass-through when full, even if a pop occurs same edge.
//   - enq_wr==0 is accepted (handshake completes) but discarded: no entry, count unchanged.
//   - Outputs write/WR/WD are combinational from head entry: write = (count!=0) & ~wb_hold;
//     WR/WD = head entry when count!=0, else 0.
//   - Pop on posedge when write==1. Latency: request accepted at edge N -> write=1 in cycle N..N+1,
//     committed in reg_file at edge N+1 (empty queue, no hold). Min latency 1 cycle, no bypass.
//   - Simultaneous enq+pop: count unchanged, both pointers advance; legal at any count < DEPTH.
//   - Same register queued twice: both writes issued in order; reg_file ends with the younger data.
//   - wb_hold held: queue fills, enq_ready drops at count==DEPTH; no entry lost or reordered.
//   - Reset mid-operation: all pending writes dropped; no write pulse after reset deasserts until
//     a new enq.
// CONFIGURATION
//   REG_WB_FWD_EN defined: fwd*_hit = any valid entry with wr==PRx and PRx!=0; fwd*_data = data
//     of youngest such entry (closest to tail). Head entry being written this cycle still counts
//     as pending (reg_file write lands at the edge). Purely combinational from state + PRx.
//   REG_WB_FWD_EN undefined: match logic not built; fwd*_hit=0, fwd*_data=0 constantly; the
//     pipeline must stall decode while count!=0.
// STRUCTURE
//   reg_pkg: REG_ADDR_W=5, REG_DATA_W=32, REG_NUM=32, REG_ZERO=5'd0, typedef wb_entry_t
//     {valid, wr, wd}. Shared with reg_file and the hazard unit.
//   Sub-module reg_wb_fwd_match: one instance per read port; age-ordered priority search over
//     DEPTH entries given head pointer; instantiated only under REG_WB_FWD_EN.
// TESTING
//   1 reset low mid-stream with 3 entries -> count=0, write=0 immediately; no write after release.
//   2 enq (WR=4, WD=31), no hold -> next cycle write=1 WR=4 WD=31; reg_file[4]==31 after edge.
//   3 wb_hold=1, enq 4 writes (r1..r4 = 10,11,12,13) -> enq_ready=0 at count 4; release hold ->
//     writes r1..r4 in order on 4 consecutive cycles, count back to 0.
//   4 enq r7=5 then r7=9, PR1=7 (FWD_EN) -> fwd1_hit=1 fwd1_data=9; after both drain hit=0, RD1=9.
//   5 enq WR=0 WD=99 -> enq accepted, count stays 0, write never asserted; PR2=0 -> fwd2_hit=0.
//   6 full queue, simultaneous enq_valid and pop -> enq_ready=0 that cycle, count 4->3, no loss.

Source files
------------

// File: rtl/reg_wb_queue_pkg.sv
// Shared register-file definitions used by reg_wb_queue, reg_file and the hazard unit.
package reg_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_NUM    = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One pending writeback: destination register and its data.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wr;
    logic [REG_DATA_W-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_queue_if.sv
// Writeback-queue bus: MEM/WB enqueue side, reg_file write port, decode forwarding taps.
interface reg_wb_queue_if
  import reg_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_wr;
  logic [DATA_W-1:0] enq_wd;
  logic              wb_hold;
  logic              write;
  logic [ADDR_W-1:0] WR;
  logic [DATA_W-1:0] WD;
  logic [ADDR_W-1:0] PR1;
  logic [ADDR_W-1:0] PR2;
  logic              fwd1_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd2_data;
  logic [CNT_W-1:0]  count;

  // Pipeline side: issues writebacks and read addresses.
  modport master (
    output enq_valid, enq_wr, enq_wd, wb_hold, PR1, PR2,
    input  enq_ready, write, WR, WD, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
  );

  // Queue side.
  modport slave (
    input  enq_valid, enq_wr, enq_wd, wb_hold, PR1, PR2,
    output enq_ready, write, WR, WD, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
  );

endinterface

// File: rtl/reg_wb_queue_fwd_match.sv
// Age-ordered search of the writeback queue for the youngest valid entry matching one read address.
module reg_wb_fwd_match
  import reg_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_wr,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_wd,
  input  logic [$clog2(DEPTH)-1:0]     i_head,
  input  logic [ADDR_W-1:0]            i_pr,
  output logic                         o_hit_c,
  output logic [DATA_W-1:0]            o_data_c
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  function automatic logic [PTR_W-1:0] age_idx(input logic [PTR_W-1:0] head, input int k);
    return head + PTR_W'(k);
  endfunction

  // Walk oldest to youngest so the last match wins; register zero never forwards.
  always_comb begin
    o_hit_c  = 1'b0;
    o_data_c = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (i_valid[age_idx(i_head, k)] && (i_wr[age_idx(i_head, k)] == i_pr) &&
          (i_pr != ADDR_W'(REG_ZERO))) begin
        o_hit_c  = 1'b1;
        o_data_c = i_wd[age_idx(i_head, k)];
      end
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// Writeback queue in front of reg_file's single write port: FIFO of pending register writes,
// drained oldest first, one per cycle unless wb_hold. Forwarding of pending data to the decode
// read ports is built only when REG_WB_FWD_EN is defined.
module reg_wb_queue
  import reg_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  reg_wb_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;
  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] r_wr;
  logic [DEPTH-1:0][DATA_W-1:0] r_wd;

  logic w_full;
  logic w_nonempty;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_nonempty = (r_count != '0) & r_valid[r_head];
  // Writes to register zero complete the handshake but occupy no slot.
  assign w_push     = bus.enq_valid & ~w_full & (bus.enq_wr != ADDR_W'(REG_ZERO));
  assign w_pop      = w_nonempty & ~bus.wb_hold;

  assign bus.enq_ready = ~w_full;
  assign bus.write     = w_pop;
  assign bus.WR        = w_nonempty ? r_wr[r_head] : '0;
  assign bus.WD        = w_nonempty ? r_wd[r_head] : '0;
  assign bus.count     = r_count;

  // Pointer, occupancy and valid-bit bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload storage; contents are qualified by r_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wr[r_tail] <= bus.enq_wr;
      r_wd[r_tail] <= bus.enq_wd;
    end
  end

`ifdef REG_WB_FWD_EN
  reg_wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
    .i_valid  (r_valid),
    .i_wr     (r_wr),
    .i_wd     (r_wd),
    .i_head   (r_head),
    .i_pr     (bus.PR1),
    .o_hit_c  (bus.fwd1_hit),
    .o_data_c (bus.fwd1_data)
  );

  reg_wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
    .i_valid  (r_valid),
    .i_wr     (r_wr),
    .i_wd     (r_wd),
    .i_head   (r_head),
    .i_pr     (bus.PR2),
    .o_hit_c  (bus.fwd2_hit),
    .o_data_c (bus.fwd2_data)
  );
`else
  // Without forwarding decode stalls while entries are pending; read addresses have no consumer.
  logic w_unused_pr;
  assign w_unused_pr   = ^{bus.PR1, bus.PR2};
  assign bus.fwd1_hit  = 1'b0;
  assign bus.fwd1_data = '0;
  assign bus.fwd2_hit  = 1'b0;
  assign bus.fwd2_data = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Scoreboard bench for reg_wb_queue: directed scenarios followed by random traffic.
module tb_reg_wb_queue;
  import reg_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  reg_wb_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;
  } req_t;

  req_t exp_q[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  bit   mon_en    = 1'b0;
  bit   full_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest pending write for a read address, found by scanning the pending list backwards.
  function automatic void model_fwd(input logic [ADDR_W-1:0] pr, output logic hit,
                                    output logic [DATA_W-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (pr != 0) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].wr == pr) begin
          hit  = 1'b1;
          data = exp_q[i].wd;
          break;
        end
      end
    end
`ifndef REG_WB_FWD_EN
    hit  = 1'b0;
    data = '0;
`endif
  endfunction

  task automatic monitor_step();
    int                sz;
    logic              h;
    logic [DATA_W-1:0] d;
    logic              exp_write;
    req_t              e;
    sz        = exp_q.size();
    full_seen = (sz == int'(DEPTH));
    chk("count", 64'(bus.count), 64'(sz));
    chk("enq_ready", 64'(bus.enq_ready), 64'(sz != int'(DEPTH)));
    model_fwd(bus.PR1, h, d);
    chk("fwd1_hit", 64'(bus.fwd1_hit), 64'(h));
    chk("fwd1_data", 64'(bus.fwd1_data), 64'(d));
    model_fwd(bus.PR2, h, d);
    chk("fwd2_hit", 64'(bus.fwd2_hit), 64'(h));
    chk("fwd2_data", 64'(bus.fwd2_data), 64'(d));
    exp_write = (sz != 0) && !bus.wb_hold;
    chk("write", 64'(bus.write), 64'(exp_write));
    if (sz != 0) begin
      chk("WR", 64'(bus.WR), 64'(exp_q[0].wr));
      chk("WD", 64'(bus.WD), 64'(exp_q[0].wd));
      if (exp_write) e = exp_q.pop_front();
    end else begin
      chk("WR_idle", 64'(bus.WR), 64'd0);
      chk("WD_idle", 64'(bus.WD), 64'd0);
    end
  endtask

  // Monitor: samples mid-cycle after inputs settle, before the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) monitor_step();
    end
  end

  // Drive one cycle of stimulus; record the request if the queue model says it is accepted.
  task automatic drive(input logic v, input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd,
                       input logic hold, input logic [ADDR_W-1:0] p1, input logic [ADDR_W-1:0] p2);
    req_t r;
    @(negedge clk);
    bus.enq_valid = v;
    bus.enq_wr    = wr;
    bus.enq_wd    = wd;
    bus.wb_hold   = hold;
    bus.PR1       = p1;
    bus.PR2       = p2;
    #4;
    if (v && !full_seen && wr != 0) begin
      r.wr = wr;
      r.wd = wd;
      exp_q.push_back(r);
    end
  endtask

  task automatic idle(input int n, input logic [ADDR_W-1:0] p1, input logic [ADDR_W-1:0] p2);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, p1, p2);
  endtask

  initial begin
    bus.enq_valid = 1'b0;
    bus.enq_wr    = '0;
    bus.enq_wd    = '0;
    bus.wb_hold   = 1'b0;
    bus.PR1       = '0;
    bus.PR2       = '0;

    // Reset values
    #12;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    chk("rst_write", 64'(bus.write), 64'd0);
    chk("rst_WR", 64'(bus.WR), 64'd0);
    chk("rst_WD", 64'(bus.WD), 64'd0);
    chk("rst_fwd1_hit", 64'(bus.fwd1_hit), 64'd0);
    chk("rst_fwd2_hit", 64'(bus.fwd2_hit), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single write, one-cycle latency
    drive(1'b1, 5'd4, 32'd31, 1'b0, 5'd4, 5'd0);
    idle(2, 5'd4, 5'd0);

    // Fill under hold, try while full, then pop and enqueue on the same edge while full
    for (int i = 1; i <= 4; i++) drive(1'b1, ADDR_W'(i), DATA_W'(9 + i), 1'b1, 5'd2, 5'd3);
    drive(1'b1, 5'd20, 32'd77, 1'b1, 5'd2, 5'd20);
    drive(1'b1, 5'd21, 32'd88, 1'b0, 5'd1, 5'd21);
    idle(5, 5'd1, 5'd4);

    // Same register twice: youngest data forwarded, both writes issued in order
    drive(1'b1, 5'd7, 32'd5, 1'b1, 5'd7, 5'd7);
    drive(1'b1, 5'd7, 32'd9, 1'b1, 5'd7, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7);
    idle(3, 5'd7, 5'd7);

    // Register zero is accepted but never written or forwarded
    drive(1'b1, 5'd0, 32'd99, 1'b0, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);

    // Reset mid-stream with three pending entries
    for (int i = 0; i < 3; i++) drive(1'b1, ADDR_W'(i + 3), DATA_W'(100 + i), 1'b1, 5'd3, 5'd5);
    @(negedge clk);
    bus.enq_valid = 1'b0;
    mon_en        = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_write", 64'(bus.write), 64'd0);
    chk("midrst_enq_ready", 64'(bus.enq_ready), 64'd1);
    chk("midrst_fwd1_hit", 64'(bus.fwd1_hit), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n       = 1'b1;
    bus.wb_hold = 1'b0;
    full_seen   = 1'b0;
    mon_en      = 1'b1;
    idle(4, 5'd3, 5'd5);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
            1'($urandom_range(0, 9) < 3), ADDR_W'($urandom_range(0, 7)),
            ADDR_W'($urandom_range(0, 7)));
    end

    // Drain
    idle(8, ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
    chk("drained_count", 64'(bus.count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
